// File: rtl/mod_mul_seq_pkg.sv
// Shared definitions for the modular-multiply sequencer: widths, state codes,
// curve moduli and their Montgomery r2 constants.
package mod_mul_seq_pkg;

    localparam int W_MONT = 381;

    localparam logic [2:0] ST_IDLE    = 3'd0;
    localparam logic [2:0] ST_M1_GO   = 3'd1;
    localparam logic [2:0] ST_M1_WAIT = 3'd2;
    localparam logic [2:0] ST_M2_GO   = 3'd3;
    localparam logic [2:0] ST_M2_WAIT = 3'd4;
    localparam logic [2:0] ST_FIN     = 3'd5;

    typedef enum logic [2:0] {
        IDLE    = ST_IDLE,
        M1_GO   = ST_M1_GO,
        M1_WAIT = ST_M1_WAIT,
        M2_GO   = ST_M2_GO,
        M2_WAIT = ST_M2_WAIT,
        FIN     = ST_FIN
    } state_t;

    // BLS12-381 base field prime p and subgroup order n
    localparam logic [W_MONT-1:0] P_BLS =
        381'h1a0111ea397fe69a4b1ba7b6434bacd764774b84f38512bf6730d2a0f6b0f6241eabfffeb153ffffb9feffffffffaaab;
    localparam logic [W_MONT-1:0] N_BLS =
        381'h73eda753299d7d483339d80809a1d80553bda402fffe5bfeffffffff00000001;

    // 2^(2*W_MONT) mod m by repeated modular doubling; elaboration-time use only
    function automatic logic [W_MONT-1:0] calc_r2(input logic [W_MONT-1:0] m);
        logic [W_MONT:0] r;
        r = {{W_MONT{1'b0}}, 1'b1};
        for (int i = 0; i < 2 * W_MONT; i++) begin
            r = {r[W_MONT-1:0], 1'b0};
            if (r >= {1'b0, m}) begin
                r = r - {1'b0, m};
            end
        end
        return r[W_MONT-1:0];
    endfunction

    localparam logic [W_MONT-1:0] R2_P = calc_r2(P_BLS);
    localparam logic [W_MONT-1:0] R2_N = calc_r2(N_BLS);

endpackage

// File: rtl/mod_mul_seq.sv
// Sequences two Montgomery multiplications (a*r2, then t*b) to give a*b mod m.
// Optional MODMUL_PERF_CNT_EN adds a 'cycles' port reporting per-operation latency.
module mod_mul_seq
    import mod_mul_seq_pkg::*;
#(
    parameter int W = W_MONT
) (
    input  logic         clk,
    input  logic         resetn,
    input  logic         start,
    input  logic [W-1:0] in_a,
    input  logic [W-1:0] in_b,
    input  logic [W-1:0] in_m,
    input  logic [W-1:0] in_r2,
    output logic [W-1:0] result,
    output logic         done,
    output logic         busy,
    output logic         mul_start,
    output logic [W-1:0] mul_a,
    output logic [W-1:0] mul_b,
    output logic [W-1:0] mul_m,
    input  logic [W-1:0] mul_result,
    input  logic         mul_done
`ifdef MODMUL_PERF_CNT_EN
    ,
    output logic [31:0]  cycles
`endif
);

    state_t       state_reg;
    logic [W-1:0] a_reg;
    logic [W-1:0] b_reg;
    logic [W-1:0] m_reg;
    logic [W-1:0] r2_reg;
    logic [W-1:0] t_reg;
    logic         pass2_reg;

    // Operand select flips only on entry to M2_GO, so operands hold through each mul_done
    assign mul_a = pass2_reg ? t_reg : a_reg;
    assign mul_b = pass2_reg ? b_reg : r2_reg;
    assign mul_m = m_reg;

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            state_reg <= IDLE;
            a_reg     <= '0;
            b_reg     <= '0;
            m_reg     <= '0;
            r2_reg    <= '0;
            t_reg     <= '0;
            pass2_reg <= 1'b0;
            result    <= '0;
            done      <= 1'b0;
            busy      <= 1'b0;
            mul_start <= 1'b0;
        end else begin
            done      <= 1'b0;
            mul_start <= 1'b0;
            case (state_reg)
                IDLE: begin
                    if (start) begin
                        a_reg     <= in_a;
                        b_reg     <= in_b;
                        m_reg     <= in_m;
                        r2_reg    <= in_r2;
                        pass2_reg <= 1'b0;
                        busy      <= 1'b1;
                        mul_start <= 1'b1;
                        state_reg <= M1_GO;
                    end
                end
                M1_GO: state_reg <= M1_WAIT;
                M1_WAIT: begin
                    // mul_result is only valid in the mul_done cycle itself
                    if (mul_done) begin
                        t_reg     <= mul_result;
                        pass2_reg <= 1'b1;
                        mul_start <= 1'b1;
                        state_reg <= M2_GO;
                    end
                end
                M2_GO: state_reg <= M2_WAIT;
                M2_WAIT: begin
                    if (mul_done) begin
                        result    <= mul_result;
                        done      <= 1'b1;
                        state_reg <= FIN;
                    end
                end
                FIN: begin
                    busy      <= 1'b0;
                    state_reg <= IDLE;
                end
                default: state_reg <= IDLE;
            endcase
        end
    end

`ifdef MODMUL_PERF_CNT_EN
    logic [31:0] cnt_reg;
    logic [31:0] cnt_next;

    assign cnt_next = (cnt_reg == 32'hffff_ffff) ? cnt_reg : cnt_reg + 32'd1;

    // FIN loads the count including the FIN cycle itself
    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            cnt_reg <= '0;
            cycles  <= '0;
        end else begin
            if (state_reg == IDLE && start) begin
                cnt_reg <= '0;
            end else if (busy) begin
                cnt_reg <= cnt_next;
            end
            if (state_reg == FIN) begin
                cycles <= cnt_next;
            end
        end
    end
`endif

endmodule

// File: tb/tb_mod_mul_seq.sv
// Self-checking bench for mod_mul_seq with a behavioural Montgomery multiplier
// of programmable latency and a transaction-level expected-output model.
module tb_mod_mul_seq;
    import mod_mul_seq_pkg::*;

    localparam int W = W_MONT;
    typedef logic [W-1:0] word_t;
    typedef logic [1023:0] wide_t;

    logic  clk;
    logic  resetn;
    logic  start;
    word_t in_a, in_b, in_m, in_r2;
    word_t result;
    logic  done, busy, mul_start;
    word_t mul_a, mul_b, mul_m;
    word_t mul_result;
    logic  mul_done;
`ifdef MODMUL_PERF_CNT_EN
    logic [31:0] cycles;
`endif

    int checks;
    int failures;
    int lat;
    bit spur;

    mod_mul_seq dut (
        .clk        (clk),
        .resetn     (resetn),
        .start      (start),
        .in_a       (in_a),
        .in_b       (in_b),
        .in_m       (in_m),
        .in_r2      (in_r2),
        .result     (result),
        .done       (done),
        .busy       (busy),
        .mul_start  (mul_start),
        .mul_a      (mul_a),
        .mul_b      (mul_b),
        .mul_m      (mul_m),
        .mul_result (mul_result),
        .mul_done   (mul_done)
`ifdef MODMUL_PERF_CNT_EN
        ,
        .cycles     (cycles)
`endif
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    function automatic word_t mod_prod(input word_t a, input word_t b, input word_t m);
        wide_t x;
        x = wide_t'(a) * wide_t'(b);
        return word_t'(x % wide_t'(m));
    endfunction

    // a*b*2^-W mod m, by REDC on the full product
    function automatic word_t mont(input word_t a, input word_t b, input word_t m);
        wide_t t;
        t = wide_t'(a) * wide_t'(b);
        for (int i = 0; i < W; i++) begin
            if (t[0]) t = t + wide_t'(m);
            t = t >> 1;
        end
        if (t >= wide_t'(m)) t = t - wide_t'(m);
        return word_t'(t);
    endfunction

    function automatic word_t rand_word(input word_t m);
        word_t x;
        x = '0;
        for (int k = 0; k < 12; k++) x = {x[W-33:0], 32'($urandom)};
        return word_t'(wide_t'(x) % wide_t'(m));
    endfunction

    task automatic chk(input string name, input wide_t act, input wide_t exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    // Behavioural multiplier: mul_done L cycles after the mul_start cycle
    initial begin
        int    pend;
        word_t ra, rb, rm, res;
        pend = 0;
        ra = '0; rb = '0; rm = '0; res = '0;
        mul_done = 1'b0;
        mul_result = '0;
        forever begin
            @(posedge clk);
            #1;
            mul_done = 1'b0;
            mul_result = '0;
            if (!resetn) begin
                pend = 0;
            end else begin
                if (pend > 0) begin
                    pend--;
                    if (pend == 0) begin
                        chk("mul_a_stable", wide_t'(mul_a), wide_t'(ra));
                        chk("mul_b_stable", wide_t'(mul_b), wide_t'(rb));
                        chk("mul_m_stable", wide_t'(mul_m), wide_t'(rm));
                        mul_done = 1'b1;
                        mul_result = res;
                    end
                end else if (spur) begin
                    mul_done = 1'b1;
                    mul_result = word_t'($urandom);
                    spur = 1'b0;
                end
                if (mul_start) begin
                    ra = mul_a; rb = mul_b; rm = mul_m;
                    res = mont(mul_a, mul_b, mul_m);
                    pend = lat;
                end
            end
        end
    end

    // Expected outputs from the operation timeline: busy 2L+3 cycles, done in the last
    initial begin
        int          rem, op_lat;
        bit          after_fin;
        word_t       exp_res, pend_res, exp_m;
        logic [31:0] exp_cyc;
        rem = 0; op_lat = 0; after_fin = 1'b0;
        exp_res = '0; pend_res = '0; exp_m = '0; exp_cyc = '0;
        forever begin
            @(negedge clk);
            if (!resetn) begin
                rem = 0; exp_res = '0; exp_cyc = '0; after_fin = 1'b0;
            end else begin
                if (after_fin) exp_cyc = 32'(2 * op_lat + 3);
                if (rem == 1) exp_res = pend_res;
            end
            chk("busy", wide_t'(busy), wide_t'(rem > 0));
            chk("done", wide_t'(done), wide_t'(rem == 1));
            chk("mul_start", wide_t'(mul_start),
                wide_t'(rem > 0 && (rem == 2 * op_lat + 3 || rem == op_lat + 2)));
            chk("result", wide_t'(result), wide_t'(exp_res));
            if (rem > 0) chk("mul_m", wide_t'(mul_m), wide_t'(exp_m));
`ifdef MODMUL_PERF_CNT_EN
            chk("cycles", wide_t'(cycles), wide_t'(exp_cyc));
`endif
            after_fin = (rem == 1);
            if (rem > 0) begin
                rem--;
            end else if (start && resetn) begin
                rem = 2 * lat + 3;
                op_lat = lat;
                pend_res = mod_prod(in_a, in_b, in_m);
                exp_m = in_m;
            end
        end
    end

    task automatic run_op(input word_t a, input word_t b, input word_t m, input word_t r2,
                          input int l, input int poke, output word_t res, output int n);
        lat = l;
        in_a = a; in_b = b; in_m = m; in_r2 = r2;
        start = 1'b1;
        @(posedge clk);
        #1;
        start = 1'b0;
        n = 1;
        while (!done && n < 1000) begin
            if (n == poke) begin
                in_a = a ^ word_t'(5);
                in_b = b + word_t'(1);
                start = 1'b1;
            end else begin
                start = 1'b0;
            end
            @(posedge clk);
            #1;
            n++;
        end
        start = 1'b0;
        res = result;
        if (!done) begin
            checks++;
            failures++;
            $display("FAIL done_timeout: got no done after %0d cycles", n);
        end
        @(posedge clk);
        #1;
    endtask

    task automatic reset_mid(input word_t a, input word_t b, input int l);
        lat = l;
        in_a = a; in_b = b; in_m = P_BLS; in_r2 = R2_P;
        start = 1'b1;
        @(posedge clk);
        #1;
        start = 1'b0;
        repeat (l + 4) @(posedge clk);
        #2;
        resetn = 1'b0;
        #1;
        chk("rst_result", wide_t'(result), wide_t'(0));
        chk("rst_busy", wide_t'(busy), wide_t'(0));
        chk("rst_done", wide_t'(done), wide_t'(0));
        @(posedge clk);
        @(posedge clk);
        #2;
        resetn = 1'b1;
        @(posedge clk);
        #1;
    endtask

    initial begin
        word_t r, a, b, m, r2;
        int    n;
        checks = 0; failures = 0; lat = 10; spur = 1'b0;
        resetn = 1'b0; start = 1'b0;
        in_a = '0; in_b = '0; in_m = '0; in_r2 = '0;
        repeat (3) @(posedge clk);
        #2;
        resetn = 1'b1;
        @(posedge clk);
        #1;

        run_op(word_t'(2), word_t'(3), P_BLS, R2_P, 10, 0, r, n);
        chk("basic_result", wide_t'(r), wide_t'(6));
        chk("basic_latency", wide_t'(n), wide_t'(23));
`ifdef MODMUL_PERF_CNT_EN
        chk("perf_cycles", wide_t'(cycles), wide_t'(23));
`endif

        run_op(P_BLS - word_t'(1), P_BLS - word_t'(1), P_BLS, R2_P, 3, 0, r, n);
        chk("max_result", wide_t'(r), wide_t'(1));
        chk("max_latency", wide_t'(n), wide_t'(9));

        run_op(word_t'(0), word_t'(12345), P_BLS, R2_P, 2, 0, r, n);
        chk("zero_result", wide_t'(r), wide_t'(0));

        run_op(word_t'(11), word_t'(13), P_BLS, R2_P, 10, 3, r, n);
        chk("ignored_start_result", wide_t'(r), wide_t'(143));
        chk("ignored_start_latency", wide_t'(n), wide_t'(23));

        run_op(word_t'(5), word_t'(7), P_BLS, R2_P, 1, 0, r, n);
        chk("b2b_result", wide_t'(r), wide_t'(35));
        chk("b2b_latency", wide_t'(n), wide_t'(5));

        spur = 1'b1;
        repeat (3) @(posedge clk);
        #1;
        chk("spurious_done_result", wide_t'(result), wide_t'(35));

        reset_mid(word_t'(9), word_t'(9), 10);
        run_op(word_t'(4), word_t'(4), P_BLS, R2_P, 10, 0, r, n);
        chk("after_reset_result", wide_t'(r), wide_t'(16));

        for (int i = 0; i < 10; i++) begin
            m  = (i % 2 == 0) ? P_BLS : N_BLS;
            r2 = (i % 2 == 0) ? R2_P : R2_N;
            a = rand_word(m);
            b = rand_word(m);
            run_op(a, b, m, r2, int'($urandom_range(1, 12)), 0, r, n);
            chk("rand_result", wide_t'(r), wide_t'(mod_prod(a, b, m)));
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
